// File: rtl/sop_eval_pipe.sv
// Registered, programmable N_IN-input Boolean function evaluator with a serially reloadable truth table.
// Optional macro SOP_EVAL_STATS_EN adds a saturating count of accepted vectors whose result is 1 (true_cnt).
module sop_eval_pipe #(
    parameter int                     N_IN     = 3,
    parameter logic [(2**N_IN)-1:0]   RESET_TT = 8'hB8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_start,
    input  logic            load_en,
    input  logic            load_bit,
    output logic            load_done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_vec,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_f
`ifdef SOP_EVAL_STATS_EN
    ,
    output logic [15:0]     true_cnt
`endif
);

    localparam int              TT_BITS  = 2**N_IN;
    localparam logic [N_IN-1:0] CNT_LAST = N_IN'(TT_BITS - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [TT_BITS-1:0]  tt_r;
    logic [N_IN-1:0]     cnt_r;
    logic                out_valid_r;
    logic                out_f_r;
    logic                load_done_r;
    logic                last_write_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                result_s;

    function automatic logic tt_lookup(input logic [TT_BITS-1:0] tt, input logic [N_IN-1:0] idx);
        return tt[idx];
    endfunction

    // Next-state logic; flags the final table write so LOAD exits on it
    always_comb begin
        state_nx_s   = state_r;
        last_write_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (load_start) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (load_en && (cnt_r == CNT_LAST)) begin
                    last_write_s = 1'b1;
                    state_nx_s   = ST_RUN;
                end else begin
                    state_nx_s   = ST_LOAD;
                end
            end
            default: begin
                state_nx_s = ST_RUN;
            end
        endcase
    end

    // Input handshake; rst_n gating keeps in_ready low while reset is asserted
    always_comb begin
        in_ready_s = 1'b0;
        if (rst_n && (state_r == ST_RUN) && !load_start && (!out_valid_r || out_ready)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = in_valid && in_ready_s;
    assign result_s = tt_lookup(tt_r, in_vec);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Truth table and load counter; the counter idles at zero in RUN so entering LOAD starts from entry 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_r  <= RESET_TT;
            cnt_r <= '0;
        end else if (state_r == ST_RUN) begin
            cnt_r <= '0;
        end else if (load_en) begin
            tt_r[cnt_r] <= load_bit;
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + N_IN'(1'b1);
            end
        end
    end

    // Single-entry output register; out_f holds its value whenever nothing new is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_f_r     <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_f_r     <= result_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Completion pulse, registered one cycle after the final table write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_done_r <= 1'b0;
        end else begin
            load_done_r <= last_write_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_f     = out_f_r;
    assign load_done = load_done_r;

`ifdef SOP_EVAL_STATS_EN
    logic [15:0] true_cnt_r;

    // Saturating true-result counter; zero is visible in the load_done cycle, accepts from then on count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            true_cnt_r <= 16'h0000;
        end else if (last_write_s) begin
            true_cnt_r <= 16'h0000;
        end else if (accept_s && result_s && (true_cnt_r != 16'hFFFF)) begin
            true_cnt_r <= true_cnt_r + 16'h0001;
        end
    end

    assign true_cnt = true_cnt_r;
`endif

endmodule

// File: tb/tb_sop_eval_pipe.sv
// Self-checking bench for sop_eval_pipe: vector tables, handshake/load corner sequences, randomized run vs. a truth-table model.
// Stats checks are compiled in when SOP_EVAL_STATS_EN is defined.
module tb_sop_eval_pipe;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       load_start = 1'b0;
    logic       load_en    = 1'b0;
    logic       load_bit   = 1'b0;
    logic       in_valid   = 1'b0;
    logic       out_ready  = 1'b0;
    logic [2:0] in_vec     = 3'd0;
    logic       load_done;
    logic       in_ready;
    logic       out_valid;
    logic       out_f;
`ifdef SOP_EVAL_STATS_EN
    logic [15:0] true_cnt;
`endif

    sop_eval_pipe #(.N_IN(3), .RESET_TT(8'hB8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_en    (load_en),
        .load_bit   (load_bit),
        .load_done  (load_done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_f      (out_f)
`ifdef SOP_EVAL_STATS_EN
        ,
        .true_cnt   (true_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vec;
        logic       exp_f;
    } vec_t;

    vec_t       tv[16];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] mtt;
    logic       mvalid;
    logic       mf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tv(input int first, input int n);
        out_ready = 1'b1;
        for (int k = first; k < first + n; k++) begin
            in_vec   = tv[k].vec;
            in_valid = 1'b1;
            #1 chk("tv_in_ready", in_ready, 1);
            tick;
            chk("tv_out_valid", out_valid, 1);
            chk($sformatf("tv_out_f[%0d]", k), out_f, tv[k].exp_f);
        end
        in_valid = 1'b0;
        tick;
        chk("tv_idle_valid", out_valid, 0);
        chk("tv_idle_hold", out_f, tv[first+n-1].exp_f);
    endtask

    task automatic check_vec(input logic [2:0] v, input logic e);
        in_vec    = v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk("cv_in_ready", in_ready, 1);
        tick;
        chk("cv_out_valid", out_valid, 1);
        chk($sformatf("cv_out_f[%0d]", v), out_f, e);
        in_valid = 1'b0;
        tick;
        chk("cv_drain", out_valid, 0);
    endtask

    task automatic load_bits(input logic [7:0] val, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            load_en  = 1'b1;
            load_bit = val[i];
            #1 chk("ld_in_ready", in_ready, 0);
            tick;
            load_en  = 1'b0;
            load_bit = 1'b0;
            chk($sformatf("ld_done[%0d]", i), load_done, (i == 7));
            if (i == 7) begin
`ifdef SOP_EVAL_STATS_EN
                chk("cnt_clear_on_done", true_cnt, 0);
`endif
                tick;
                chk("ld_done_one_cycle", load_done, 0);
            end else if (gaps) begin
                repeat ($urandom_range(1, 2)) begin
                    tick;
                    chk("ld_gap_no_done", load_done, 0);
                end
            end
        end
        mtt = val;
    endtask

    task automatic load_table(input logic [7:0] val, input bit gaps);
        load_start = 1'b1;
        #1 chk("ls_in_ready", in_ready, 0);
        tick;
        load_start = 1'b0;
        load_bits(val, gaps);
    endtask

    initial begin
        logic       rdy_e;
        logic       acc;
        logic [2:0] v;
        logic [7:0] lv;

        // xy' + yz: bits 3,4,5,7 set; 8'h96 reload table
        tv[0]  = '{3'd0, 1'b0}; tv[1]  = '{3'd1, 1'b0}; tv[2]  = '{3'd2, 1'b0}; tv[3]  = '{3'd3, 1'b1};
        tv[4]  = '{3'd4, 1'b1}; tv[5]  = '{3'd5, 1'b1}; tv[6]  = '{3'd6, 1'b0}; tv[7]  = '{3'd7, 1'b1};
        tv[8]  = '{3'd0, 1'b0}; tv[9]  = '{3'd1, 1'b1}; tv[10] = '{3'd2, 1'b1}; tv[11] = '{3'd3, 1'b0};
        tv[12] = '{3'd4, 1'b1}; tv[13] = '{3'd5, 1'b0}; tv[14] = '{3'd6, 1'b0}; tv[15] = '{3'd7, 1'b1};
        mtt = 8'hB8;

        // reset state
        in_valid = 1'b1;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_f", out_f, 0);
        chk("rst_load_done", load_done, 0);
`ifdef SOP_EVAL_STATS_EN
        chk("rst_true_cnt", true_cnt, 0);
`endif
        in_valid = 1'b0;
        #9 rst_n = 1'b1;
        tick;

        // reset-table sweep, back-to-back
        run_tv(0, 8);

        // backpressure: second vector stalls while out_ready=0
        out_ready = 1'b0;
        in_vec    = 3'd4;
        in_valid  = 1'b1;
        tick;
        chk("bp_valid", out_valid, 1);
        chk("bp_f", out_f, 1);
        in_vec = 3'd0;
        #1 chk("bp_stall_ready", in_ready, 0);
        tick;
        chk("bp_hold_f", out_f, 1);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        tick;
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_f", out_f, 0);
        in_valid = 1'b0;
        tick;
        chk("bp_drained", out_valid, 0);

        // reload 8'h96 with gaps, then sweep
        load_table(8'h96, 1'b1);
        run_tv(8, 8);

        // pending result across load_start with simultaneous in_valid
        out_ready = 1'b0;
        in_vec    = 3'd7;
        in_valid  = 1'b1;
        tick;
        chk("pl_valid", out_valid, 1);
        chk("pl_f", out_f, 1);
        in_vec     = 3'd0;
        load_start = 1'b1;
        #1 chk("pl_ls_ready", in_ready, 0);
        tick;
        load_start = 1'b0;
        chk("pl_hold_valid", out_valid, 1);
        chk("pl_hold_f", out_f, 1);
        #1 chk("pl_load_ready", in_ready, 0);
        out_ready = 1'b1;
        tick;
        chk("pl_drain_valid", out_valid, 0);
        chk("pl_drain_f", out_f, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load_bits(8'h41, 1'b0);
        check_vec(3'd6, 1'b1);
        check_vec(3'd3, 1'b0);

        // reset mid-load restores RESET_TT
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_en  = 1'b1;
            load_bit = 1'b0;
            tick;
        end
        load_en = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mr_in_ready", in_ready, 0);
        chk("mr_load_done", load_done, 0);
        repeat (2) begin
            tick;
            chk("mr_no_done", load_done, 0);
        end
        rst_n = 1'b1;
        tick;
        chk("mr_after_done", load_done, 0);
        mtt = 8'hB8;
`ifdef SOP_EVAL_STATS_EN
        chk("st_zero", true_cnt, 0);
        run_tv(0, 8);
        run_tv(0, 8);
        chk("st_two_sweeps", true_cnt, 8);
        load_table(8'hFF, 1'b0);
        in_vec    = 3'd2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (70000) tick;
        chk("st_saturate", true_cnt, 16'hFFFF);
        in_valid = 1'b0;
        tick;
        load_table(8'hB8, 1'b0);
`endif
        check_vec(3'd3, 1'b1);
        check_vec(3'd1, 1'b0);

        // randomized traffic against a truth-table / single-slot model
        for (int r = 0; r < 3; r++) begin
            lv = 8'($urandom);
            load_table(lv, 1'b1);
            mvalid = 1'b0;
            mf     = 1'b0;
            for (int c = 0; c < 150; c++) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                in_vec    = 3'($urandom_range(0, 7));
                rdy_e     = !mvalid || out_ready;
                #1 chk("rnd_in_ready", in_ready, rdy_e);
                acc = in_valid && rdy_e;
                v   = in_vec;
                tick;
                if (acc) begin
                    mvalid = 1'b1;
                    mf     = mtt[v];
                end else if (out_ready) begin
                    mvalid = 1'b0;
                end
                chk("rnd_out_valid", out_valid, mvalid);
                if (mvalid) chk("rnd_out_f", out_f, mf);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick;
            chk("rnd_drain", out_valid, 0);
            out_ready = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
